// File: rtl/ochiba_muldiv_iter.sv
// ochiba_muldiv_iter: iterative RV32M multiply/divide unit for the Ex stage.
// One op in flight. Normal ops spend 32 RUN cycles and then pulse done.
// Divide-by-zero and signed overflow skip RUN and finish in one cycle.
module ochiba_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

  // The iteration counter is 5 bits wide because only WIDTH == 32 is supported.
  localparam logic [4:0] CNT_LAST = 5'd31;

  logic [1:0]       state_r;
  logic [4:0]       cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic [2:0]       op_r;
  logic             neg_r;
  logic [W2-1:0]    acc_r;   // multiply: partial product; divide: {remainder, dividend/quotient}
  logic [W2-1:0]    opa_r;   // multiply: shifting multiplicand; divide: divisor in the low half
  logic [WIDTH-1:0] opb_r;   // multiply: shifting multiplier

  logic             a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic             special_s;
  logic [WIDTH-1:0] special_res_s;
  logic             accept_s;
  logic [W2-1:0]    acc_nx_s;
  logic [W2-1:0]    prod_s;
  logic [WIDTH:0]   rem_sh_s, diff_s;
  logic [WIDTH-1:0] div_val_s, final_s;

  // Decode operand signedness and magnitudes from the issuing op.
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b1;
      end
      OP_MULHSU: begin
        a_sgn_s = 1'b1;
        b_sgn_s = 1'b0;
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
      end
    endcase
    a_neg_s = a_sgn_s & a[WIDTH-1];
    b_neg_s = b_sgn_s & b[WIDTH-1];
    mag_a_s = a_neg_s ? (ZERO_W - a) : a;
    mag_b_s = b_neg_s ? (ZERO_W - b) : b;
  end

  // Detect the single-cycle divide cases and their fixed results.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = ZERO_W;
    if (op[2] && (b == ZERO_W)) begin
      special_s     = 1'b1;
      special_res_s = op[1] ? a : ONES_W;
    end else if (((op == OP_DIV) || (op == OP_REM)) && (a == MIN_W) && (b == ONES_W)) begin
      special_s     = 1'b1;
      special_res_s = op[1] ? ZERO_W : MIN_W;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_W;
    end
  end

  // Accept is possible outside RUN; a flush in the same cycle suppresses it.
  always_comb begin
    accept_s = start & ~flush & (state_r != S_RUN);
    stall_o  = (state_r == S_RUN) | (accept_s & ~special_s);
  end

  // One iteration: a shift-add step for multiply, a restoring step for divide.
  always_comb begin
    acc_nx_s = acc_r;
    rem_sh_s = {acc_r[W2-1:WIDTH], acc_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, opa_r[WIDTH-1:0]};
    if (op_r[2]) begin
      if (!diff_s[WIDTH]) begin
        acc_nx_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else if (opb_r[0]) begin
      acc_nx_s = acc_r + opa_r;
    end else begin
      acc_nx_s = acc_r;
    end
  end

  // Apply the sign and select the result half, from the value after the final step.
  always_comb begin
    prod_s    = neg_r ? ({W2{1'b0}} - acc_nx_s) : acc_nx_s;
    div_val_s = op_r[1] ? acc_nx_s[W2-1:WIDTH] : acc_nx_s[WIDTH-1:0];
    if (op_r[2]) begin
      final_s = neg_r ? (ZERO_W - div_val_s) : div_val_s;
    end else if (op_r[1:0] == 2'b00) begin
      final_s = prod_s[WIDTH-1:0];
    end else begin
      final_s = prod_s[W2-1:WIDTH];
    end
  end

  // Control FSM plus the datapath registers; a flush abandons the op and leaves result unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= 5'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO_W;
      op_r     <= 3'd0;
      neg_r    <= 1'b0;
      acc_r    <= {W2{1'b0}};
      opa_r    <= {W2{1'b0}};
      opb_r    <= ZERO_W;
    end else if (flush) begin
      state_r <= S_IDLE;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s && special_s) begin
            state_r  <= S_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= special_res_s;
          end else if (accept_s) begin
            state_r <= S_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            cnt_r   <= 5'd0;
            op_r    <= op;
            neg_r   <= (op[2] && op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
            if (op[2]) begin
              acc_r <= {ZERO_W, mag_a_s};
              opa_r <= {ZERO_W, mag_b_s};
              opb_r <= ZERO_W;
            end else begin
              acc_r <= {W2{1'b0}};
              opa_r <= {ZERO_W, mag_a_s};
              opb_r <= mag_b_s;
            end
          end else begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        S_RUN: begin
          acc_r <= acc_nx_s;
          cnt_r <= cnt_r + 5'd1;
          if (!op_r[2]) begin
            opa_r <= {opa_r[W2-2:0], 1'b0};
            opb_r <= {1'b0, opb_r[WIDTH-1:1]};
          end
          if (cnt_r == CNT_LAST) begin
            state_r  <= S_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            result_r <= final_s;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_ochiba_muldiv_iter.sv
// Testbench for ochiba_muldiv_iter: directed RV32M cases plus randomized ops
// checked against an arithmetic reference model.
module tb_ochiba_muldiv_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = 32'd0;
  logic [31:0] b_i = 32'd0;
  logic        flush = 1'b0;
  logic        stall_o, busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_mis = 0;

  ochiba_muldiv_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .a(a_i), .b(b_i),
    .flush(flush), .stall_o(stall_o), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference model: RV32M semantics using plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    p = 64'd0;
    r = 32'd0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin if (y == 32'd0) r = 32'hFFFFFFFF; else begin p = sx / sy; r = p[31:0]; end end
      3'd5: begin if (y == 32'd0) r = 32'hFFFFFFFF; else r = x / y; end
      3'd6: begin if (y == 32'd0) r = x; else begin p = sx % sy; r = p[31:0]; end end
      default: begin if (y == 32'd0) r = x; else r = x % y; end
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 32'd0) ||
                    (((o == 3'd4) || (o == 3'd6)) && (x == 32'h80000000) && (y == 32'hFFFFFFFF)));
  endfunction

  // Issue one op at the current negedge and follow it to its done pulse.
  // With trail=0 the task returns in the done cycle so the caller can issue back-to-back.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input bit trail, input string nm);
    bit sp;
    int exp_lat, lat, busy_n, both;
    sp = is_special(o, x, y);
    exp_lat = sp ? 1 : 33;
    start = 1'b1; op_i = o; a_i = x; b_i = y;
    #1;
    n_cmp++;
    if (stall_o !== !sp) begin
      n_mis++; $display("FAIL %s stall_at_accept: got %b expected %b", nm, stall_o, !sp);
    end
    @(posedge clk); #1;
    start = 1'b0; op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 0; busy_n = 0; both = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy && done) both++;
      if (busy) busy_n++;
      if (done) begin lat = n; break; end
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_mis++; $display("FAIL %s latency: got %0d expected %0d (0 = no done)", nm, lat, exp_lat);
    end
    n_cmp++;
    if (result !== exp) begin
      n_mis++; $display("FAIL %s result: got %h expected %h", nm, result, exp);
    end
    n_cmp++;
    if (busy_n != (sp ? 0 : 32)) begin
      n_mis++; $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy_n, sp ? 0 : 32);
    end
    n_cmp++;
    if (both != 0) begin
      n_mis++; $display("FAIL %s busy_and_done: got %0d cycles expected 0", nm, both);
    end
    if (trail) begin
      @(negedge clk);
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_mis++; $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", nm, done, busy);
      end
      n_cmp++;
      if (result !== exp) begin
        n_mis++; $display("FAIL %s result_hold: got %h expected %h", nm, result, exp);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, stall_o} !== 3'b000) begin
      n_mis++; $display("FAIL reset_ctrl: got busy=%b done=%b stall=%b expected 0 0 0", busy, done, stall_o);
    end
    n_cmp++;
    if (result !== 32'd0) begin
      n_mis++; $display("FAIL reset_result: got %h expected 00000000", result);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1, "T1_mul");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1, "T2_mulh");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "T2_mulhu");
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b1, "T2_mulhsu");
  endtask

  task automatic test_div();
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, "T3_divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 1'b1, "T3_remu");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b1, "T3_div");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b1, "T3_rem");
  endtask

  task automatic test_special();
    run_op(3'd4, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1'b1, "T4_div0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1'b1, "T4_rem0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "T4_div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b1, "T4_rem_ovf");
  endtask

  task automatic test_flush();
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, "T5_pre");
    start = 1'b1; op_i = 3'd4; a_i = 32'hFFFFFF9C; b_i = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_mis++; $display("FAIL T5_flush_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
    n_cmp++;
    if (result !== 32'd14) begin
      n_mis++; $display("FAIL T5_flush_result: got %h expected 0000000e", result);
    end
    @(negedge clk);
    run_op(3'd4, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b1, "T5_after_flush");
    start = 1'b1; flush = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
        n_mis++; $display("FAIL T5_start_with_flush: got busy=%b done=%b expected 0 0", busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "T6_b2b_first");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b0, "T6_b2b_second");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, "T6_b2b_special");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "T6_b2b_after_special");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; op_i = 3'd1; a_i = 32'h7FFFFFFF; b_i = 32'h7FFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, stall_o} !== 3'b000) begin
      n_mis++; $display("FAIL T6_reset_mid_ctrl: got busy=%b done=%b stall=%b expected 0 0 0", busy, done, stall_o);
    end
    n_cmp++;
    if (result !== 32'd0) begin
      n_mis++; $display("FAIL T6_reset_mid_result: got %h expected 00000000", result);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(3'd7, 32'hFFFFFFFF, 32'd10, 32'd5, 1'b1, "T6_after_reset");
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'd0;
      1: v = 32'h80000000;
      2: v = 32'hFFFFFFFF;
      3: v = $urandom_range(0, 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] x, y;
    bit tr;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick_val();
      y = pick_val();
      tr = (i == 39) || ($urandom_range(0, 3) != 0);
      run_op(o, x, y, ref_model(o, x, y), tr, $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
